// File: rtl/can_edge_timestamper_pkg.sv
// Shared definitions for the CAN edge timestamper.
// Contents: datapath widths, the fine-code ceiling, the synchroniser latency,
// the FIFO depth, the timestamp record type, the capture FSM state encoding
// and the fine-code clamp helper.
package can_tdc_pkg;

  localparam int COARSE_W   = 32;
  localparam int FINE_W     = 7;
  localparam int FINE_MAX   = 100;
  localparam int SYNC_LAT   = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int LEVEL_W    = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [COARSE_W-1:0] coarse;
    logic [FINE_W-1:0]   fine;
  } ts_t;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    WAIT_LOW = 2'd1,
    ARMED    = 2'd2
  } state_t;

  // Codes above the last usable tap saturate at FINE_MAX.
  function automatic logic [FINE_W-1:0] clamp_fine(input logic [FINE_W-1:0] code);
    return (code > FINE_W'(FINE_MAX)) ? FINE_W'(FINE_MAX) : code;
  endfunction

endpackage

// File: rtl/can_edge_timestamper_if.sv
// Timestamp stream between the timestamper and its consumer.
// Signals:
//   ts_valid  - head entry present (driven by master)
//   ts_ready  - consumer accepts the head (driven by slave)
//   ts_coarse - latency-compensated coarse count of the edge
//   ts_fine   - clamped TDC fine code of the edge
// Parameters CW/FW allow a narrower coarse field than the package default.
interface can_edge_timestamper_if import can_tdc_pkg::*; #(
  parameter int CW = COARSE_W,
  parameter int FW = FINE_W
);
  logic          ts_valid;
  logic          ts_ready;
  logic [CW-1:0] ts_coarse;
  logic [FW-1:0] ts_fine;

  modport master (output ts_valid, output ts_coarse, output ts_fine, input ts_ready);
  modport slave  (input ts_valid, input ts_coarse, input ts_fine, output ts_ready);
endinterface

// File: rtl/can_edge_timestamper_ts_fifo.sv
// ts_fifo: first-word-fall-through FIFO with a valid/ready read side.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   push       - write request; silently refused when full without a pop
//   push_data  - entry to store
//   ready      - consumer accepts the head this cycle
//   valid      - head entry present
//   head       - current head entry (held while ready is low)
//   level      - number of entries held
//   full       - all DEPTH entries occupied
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module ts_fifo #(
  parameter int W     = 39,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     ready,
  output logic                     valid,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;
  logic          pop_s;
  logic          push_ok_s;

  // A pop frees a slot in the same cycle, so a push while full is accepted then.
  always_comb begin
    pop_s     = (level_r != '0) & ready;
    push_ok_s = push & ((level_r != LW'(DEPTH)) | pop_s);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  assign valid = (level_r != '0);
  assign full  = (level_r == LW'(DEPTH));
  assign head  = mem_r[rd_ptr_r];
  assign level = level_r;

endmodule

// File: rtl/can_edge_timestamper.sv
// can_edge_timestamper: pairs each rising edge of the asynchronous CAN RX
// line with the coarse CLK count and the TDC fine code, queueing one
// {coarse, fine} timestamp per edge for a valid/ready consumer.
// Ports:
//   CLK, RST    - system clock, asynchronous active-high reset
//   en          - capture enable
//   CAN_logic   - raw CAN RX level, asynchronous to CLK
//   fine_time   - TDC fine code, already static when the edge is seen here
//   ts          - timestamp stream (master side)
//   fifo_level  - entries queued
//   overflow    - sticky: an edge was dropped because the queue was full
// Parameter CW narrows the coarse counter (defaults to COARSE_W).
module can_edge_timestamper import can_tdc_pkg::*; #(
  parameter int CW = COARSE_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  en,
  input  logic                  CAN_logic,
  input  logic [FINE_W-1:0]     fine_time,
  can_edge_timestamper_if.master ts,
  output logic [LEVEL_W-1:0]    fifo_level,
  output logic                  overflow
);
  logic [CW-1:0]        coarse_cnt_r;
  logic                 s1_r;
  logic                 s2_r;
  logic                 s3_r;
  logic                 edge_det_r;
  state_t               state_r;
  state_t               state_next_s;
  logic                 capture_s;
  logic [CW+FINE_W-1:0] cap_data_s;
  logic [CW+FINE_W-1:0] head_s;
  logic                 valid_s;
  logic                 full_s;
  logic                 overflow_r;

  // Free-running coarse counter, independent of en.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      coarse_cnt_r <= '0;
    end else begin
      coarse_cnt_r <= coarse_cnt_r + CW'(1);
    end
  end

  // Two-flop synchroniser, history flop and registered rising-edge pulse.
  // The pulse lands SYNC_LAT cycles after the cycle in which the line rose.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_r       <= 1'b0;
      s2_r       <= 1'b0;
      s3_r       <= 1'b0;
      edge_det_r <= 1'b0;
    end else begin
      s1_r       <= CAN_logic;
      s2_r       <= s1_r;
      s3_r       <= s2_r;
      edge_det_r <= s2_r & ~s3_r;
    end
  end

  // Capture FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= DISARMED;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state: WAIT_LOW refuses to arm on a line that is already high,
  // so the first timestamp is always a complete low-to-high transition.
  always_comb begin
    state_next_s = state_r;
    if (!en) begin
      state_next_s = DISARMED;
    end else begin
      case (state_r)
        DISARMED: state_next_s = WAIT_LOW;
        WAIT_LOW: begin
          if (!s2_r) begin
            state_next_s = ARMED;
          end else begin
            state_next_s = WAIT_LOW;
          end
        end
        ARMED:    state_next_s = ARMED;
        default:  state_next_s = DISARMED;
      endcase
    end
  end

  // Edge qualification and timestamp formation. Subtracting the synchroniser
  // latency in CW bits wraps correctly when the counter has just rolled over.
  // An edge in the cycle en falls is dropped because en gates it here.
  always_comb begin
    capture_s  = edge_det_r & en & (state_r == ARMED);
    cap_data_s = {coarse_cnt_r - CW'(SYNC_LAT), clamp_fine(fine_time)};
  end

  // The FIFO write port is the capture register: the entry becomes visible
  // the cycle after the edge pulse.
  ts_fifo #(
    .W     (CW + FINE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (capture_s),
    .push_data (cap_data_s),
    .ready     (ts.ts_ready),
    .valid     (valid_s),
    .head      (head_s),
    .level     (fifo_level),
    .full      (full_s)
  );

  // Sticky drop flag; a same-cycle pop makes room, so that edge is not lost.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      overflow_r <= 1'b0;
    end else if (capture_s & full_s & ~(valid_s & ts.ts_ready)) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  assign ts.ts_valid  = valid_s;
  assign ts.ts_coarse = head_s[CW+FINE_W-1:FINE_W];
  assign ts.ts_fine   = head_s[FINE_W-1:0];
  assign overflow     = overflow_r;

endmodule
